// File: rtl/canny_pkg.sv
// Shared image geometry and read-side FSM encoding for the Canny front end.
package canny_pkg;

    localparam int IMG_WIDTH  = 512;
    localparam int IMG_HEIGHT = 512;
    localparam int ADDR_W     = 18;
    localparam int PIXEL_W    = 8;
    localparam int COORD_W    = 9;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DONE
    } read_state_t;

endpackage

// File: rtl/read_controller_if.sv
// SRAM read bus plus downstream pixel stream seen by the read controller.
interface read_controller_if #(
    parameter int ADDR_W  = canny_pkg::ADDR_W,
    parameter int PIXEL_W = canny_pkg::PIXEL_W,
    parameter int COORD_W = canny_pkg::COORD_W
);

    logic               read_enable;
    logic [ADDR_W-1:0]  read_address;
    logic [PIXEL_W-1:0] read_data;
    logic [PIXEL_W-1:0] pixel_data;
    logic               pixel_valid;
    logic               pixel_ready;
    logic [COORD_W-1:0] x_value;
    logic [COORD_W-1:0] y_value;

    modport master (
        output read_enable, read_address,
        input  read_data,
        output pixel_data, pixel_valid, x_value, y_value,
        input  pixel_ready
    );

    modport slave (
        input  read_enable, read_address,
        output read_data,
        input  pixel_data, pixel_valid, x_value, y_value,
        output pixel_ready
    );

endinterface

// File: rtl/pixel_raster_counter.sv
// Raster-order x/y counter with linear SRAM address generation.
module pixel_raster_counter #(
    parameter int          IMG_WIDTH  = canny_pkg::IMG_WIDTH,
    parameter int          IMG_HEIGHT = canny_pkg::IMG_HEIGHT,
    parameter int          ADDR_W     = canny_pkg::ADDR_W,
    parameter int          COORD_W    = canny_pkg::COORD_W,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last_pixel,
    output logic [ADDR_W-1:0]  address
);

    logic last_col;

    assign last_col   = (x == COORD_W'(IMG_WIDTH - 1));
    assign last_pixel = last_col && (y == COORD_W'(IMG_HEIGHT - 1));

    // Linear address, truncated to the SRAM width so the full frame may fill it exactly.
    always_comb begin
        address = ADDR_W'(BASE_ADDR + 32'(y) * 32'(IMG_WIDTH) + 32'(x));
    end

    // Position update: clear to origin, or step one pixel with row wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (last_col) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/read_controller.sv
// Fetches a frame from SRAM in raster order, one outstanding read at a time,
// and hands each pixel downstream over valid/ready.
module read_controller
    import canny_pkg::*;
#(
    parameter int          IMG_WIDTH    = canny_pkg::IMG_WIDTH,
    parameter int          IMG_HEIGHT   = canny_pkg::IMG_HEIGHT,
    parameter int          ADDR_W       = canny_pkg::ADDR_W,
    parameter int          PIXEL_W      = canny_pkg::PIXEL_W,
    parameter int          READ_LATENCY = 2,
    parameter int unsigned BASE_ADDR    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    read_controller_if.master bus,
    output logic              busy,
    output logic              frame_done
);

    read_state_t        state;
    read_state_t        state_next;
    logic [2:0]         lat_cnt;
    logic               clear;
    logic               advance;
    logic               load;
    logic               capture;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               last_pixel;
    logic [ADDR_W-1:0]  address;
    logic [PIXEL_W-1:0] pixel_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;

    pixel_raster_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .ADDR_W     (ADDR_W),
        .COORD_W    (COORD_W),
        .BASE_ADDR  (BASE_ADDR)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .advance    (advance),
        .x          (x),
        .y          (y),
        .last_pixel (last_pixel),
        .address    (address)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle strobes; abort overrides everything outside IDLE.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        advance    = 1'b0;
        load       = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                load       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 3'd1) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.pixel_ready) begin
                    if (last_pixel) begin
                        state_next = DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort && state != IDLE) begin
            state_next = IDLE;
            advance    = 1'b0;
            load       = 1'b0;
            capture    = 1'b0;
        end
    end

    // Read latency countdown; the capture fires on the cycle it reads 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (load) begin
            lat_cnt <= 3'(READ_LATENCY);
        end else if (state == WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // Output pixel and coordinates, held stable until the next capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (capture) begin
            pixel_q <= bus.read_data;
            x_q     <= x;
            y_q     <= y;
        end
    end

    assign bus.read_enable  = (state == ISSUE);
    assign bus.read_address = (state == ISSUE) ? address : '0;
    assign bus.pixel_valid  = (state == HOLD);
    assign bus.pixel_data   = pixel_q;
    assign bus.x_value      = x_q;
    assign bus.y_value      = y_q;
    assign busy             = (state != IDLE);
    assign frame_done       = (state == DONE);

endmodule

// File: tb/tb_read_controller.sv
// Directed bench for read_controller on a 4x2 frame with a 3-bit SRAM space.
module tb_read_controller;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int AW  = 3;
    localparam int PW  = 8;
    localparam int LAT = 2;

    logic clk;
    logic rst;
    logic start;
    logic abort;
    logic busy;
    logic frame_done;

    int vectors;
    int miscompares;
    int n_reads;
    int n_done;
    int base_reads;
    int base_done;

    logic [PW-1:0] sram_d1;
    logic [PW-1:0] sram_d2;

    read_controller_if #(.ADDR_W(AW), .PIXEL_W(PW), .COORD_W(9)) bus_if ();

    read_controller #(
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .ADDR_W       (AW),
        .PIXEL_W      (PW),
        .READ_LATENCY (LAT),
        .BASE_ADDR    (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .bus        (bus_if),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage SRAM model returning the address as data; idle cycles return 0xEE.
    always @(posedge clk) begin
        sram_d1 <= bus_if.read_enable ? PW'(bus_if.read_address) : 8'hEE;
        sram_d2 <= sram_d1;
    end
    assign bus_if.read_data = sram_d2;

    // Event counters for read strobes and frame completions.
    initial begin
        n_reads = 0;
        n_done  = 0;
    end
    always @(posedge clk) begin
        if (bus_if.read_enable) n_reads = n_reads + 1;
        if (frame_done)         n_done  = n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entry: negedge with DUT in ISSUE. Exit: negedge after the handshake edge.
    task automatic run_pixel(input int a, input int px, input int py, input int stall,
                             input bit pulse_start);
        check("issue_re", 32'(bus_if.read_enable), 1);
        check("issue_addr", 32'(bus_if.read_address), 32'(a));
        check("issue_busy", 32'(busy), 1);
        bus_if.pixel_ready = (stall == 0);
        if (pulse_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("wait1_re", 32'(bus_if.read_enable), 0);
        check("wait1_pv", 32'(bus_if.pixel_valid), 0);
        @(negedge clk);
        check("wait2_pv", 32'(bus_if.pixel_valid), 0);
        @(negedge clk);
        check("hold_pv", 32'(bus_if.pixel_valid), 1);
        check("hold_data", 32'(bus_if.pixel_data), 32'(a));
        check("hold_x", 32'(bus_if.x_value), 32'(px));
        check("hold_y", 32'(bus_if.y_value), 32'(py));
        for (int i = 1; i < stall; i++) begin
            @(negedge clk);
            check("stall_pv", 32'(bus_if.pixel_valid), 1);
            check("stall_re", 32'(bus_if.read_enable), 0);
            check("stall_data", 32'(bus_if.pixel_data), 32'(a));
            check("stall_x", 32'(bus_if.x_value), 32'(px));
            check("stall_y", 32'(bus_if.y_value), 32'(py));
        end
        bus_if.pixel_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start_from_idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        bus_if.pixel_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_re", 32'(bus_if.read_enable), 0);
        check("rst_addr", 32'(bus_if.read_address), 0);
        check("rst_pv", 32'(bus_if.pixel_valid), 0);
        check("rst_data", 32'(bus_if.pixel_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(frame_done), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_re", 32'(bus_if.read_enable), 0);

        // Frame 1: full frame, stall on pixel (2,0), stray start on pixel 4
        base_reads = n_reads;
        base_done  = n_done;
        pulse_start_from_idle();
        for (int p = 0; p < W * H; p++) begin
            run_pixel(p, p % W, p / W, (p == 2) ? 5 : 0, (p == 4));
        end
        check("f1_done", 32'(frame_done), 1);
        check("f1_done_busy", 32'(busy), 1);
        check("f1_done_pv", 32'(bus_if.pixel_valid), 0);
        @(negedge clk);
        check("f1_after_done", 32'(frame_done), 0);
        check("f1_idle_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        check("f1_reads", 32'(n_reads - base_reads), 8);
        check("f1_frames", 32'(n_done - base_done), 1);

        // Frame 2: abort while waiting on pixel 5
        base_done = n_done;
        pulse_start_from_idle();
        for (int p = 0; p < 5; p++) begin
            run_pixel(p, p % W, p / W, 0, 1'b0);
        end
        check("ab_addr", 32'(bus_if.read_address), 5);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_pv", 32'(bus_if.pixel_valid), 0);
        check("ab_re", 32'(bus_if.read_enable), 0);
        repeat (4) @(negedge clk);
        check("ab_pv_late", 32'(bus_if.pixel_valid), 0);
        check("ab_busy_late", 32'(busy), 0);
        check("ab_no_done", 32'(n_done - base_done), 0);

        // Restart at address 0, then async reset while holding pixel 5
        pulse_start_from_idle();
        for (int p = 0; p < 5; p++) begin
            run_pixel(p, p % W, p / W, 0, 1'b0);
        end
        bus_if.pixel_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("ar_pv_before", 32'(bus_if.pixel_valid), 1);
        check("ar_data_before", 32'(bus_if.pixel_data), 5);
        #1 rst = 1'b1;
        #1;
        check("ar_pv", 32'(bus_if.pixel_valid), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_data", 32'(bus_if.pixel_data), 0);
        check("ar_x", 32'(bus_if.x_value), 0);
        check("ar_y", 32'(bus_if.y_value), 0);
        @(negedge clk);
        rst = 1'b0;
        bus_if.pixel_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ar_idle", 32'(busy), 0);
        check("ar_no_done", 32'(n_done - base_done), 0);

        // Async reset in ISSUE drops read_enable immediately
        pulse_start_from_idle();
        check("ri_re_before", 32'(bus_if.read_enable), 1);
        #1 rst = 1'b1;
        #1;
        check("ri_re", 32'(bus_if.read_enable), 0);
        check("ri_addr", 32'(bus_if.read_address), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // abort in IDLE is ignored, so the simultaneous start is honoured
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("ia_busy", 32'(busy), 1);
        check("ia_re", 32'(bus_if.read_enable), 1);
        check("ia_addr", 32'(bus_if.read_address), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ia_exit", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
